// File: rtl/vec_bram_loader_if.sv
// Request/status handshake and BRAM read port of the vector loader.
// The loader side uses the slave modport; the requester/BRAM side uses master.
interface vec_bram_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 6
);
  logic                             start_i;
  logic [ADDR_W-1:0]                base_addr_i;
  logic [LEN_W-1:0]                 len_i;
  logic                             busy_o;
  logic                             done_o;
  logic                             ready_o;
  logic                             err_o;
  logic [LANES-1:0][DATA_WIDTH-1:0] bram_dout;
  logic                             bram_en;
  logic [ADDR_W-1:0]                bram_addr;

  modport master (
    output start_i, base_addr_i, len_i, bram_dout,
    input  busy_o, done_o, ready_o, err_o, bram_en, bram_addr
  );

  modport slave (
    input  start_i, base_addr_i, len_i, bram_dout,
    output busy_o, done_o, ready_o, err_o, bram_en, bram_addr
  );
endinterface

// File: rtl/vec_bram_loader.sv
// Loads len elements from a multi-lane BRAM read port into a register vector.
// Reads are tracked through an RD_LAT-deep valid/beat-index pipe.
module vec_bram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int LEN_W      = $clog2(DEPTH+1)
) (
  input  logic                             clk,
  input  logic                             rst,
  vec_bram_loader_if.slave                 bus,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0] vec_o
);
  localparam int BEATS  = DEPTH / LANES;
  localparam int BEAT_W = $clog2(BEATS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [LEN_W-1:0]                 len_q, len_d;
  logic [BEAT_W-1:0]                nbeats_q, nbeats_d;
  logic [BEAT_W-1:0]                beat_q, beat_d;
  logic [RD_LAT-1:0]                vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][BEAT_W-1:0]    idx_pipe_q, idx_pipe_d;
  logic                             ready_q, ready_d;
  logic                             err_q, err_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] vec_q, vec_d;

  logic              len_ok, accept, issue, cap, cap_last;
  logic [BEAT_W-1:0] cap_idx;

  assign len_ok   = (bus.len_i != '0) && (int'(bus.len_i) <= DEPTH);
  assign accept   = (state_q == S_IDLE) && bus.start_i && len_ok;
  assign issue    = (state_q == S_ISSUE);
  assign cap      = vld_pipe_q[RD_LAT-1];
  assign cap_idx  = idx_pipe_q[RD_LAT-1];
  assign cap_last = cap && (cap_idx == nbeats_q - BEAT_W'(1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    nbeats_d = nbeats_q;
    beat_d   = beat_q;
    ready_d  = ready_q;
    err_d    = (state_q == S_IDLE) && bus.start_i && !len_ok;

    vld_pipe_d[0] = issue;
    idx_pipe_d[0] = beat_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      idx_pipe_d[i] = idx_pipe_q[i-1];
    end

    case (state_q)
      S_IDLE: if (accept) begin
        state_d  = S_ISSUE;
        addr_d   = bus.base_addr_i;
        len_d    = bus.len_i;
        nbeats_d = BEAT_W'((int'(bus.len_i) + LANES - 1) / LANES);
        beat_d   = '0;
        ready_d  = 1'b0;
      end
      // The address stays on the last issued beat once issuing stops.
      S_ISSUE: if (beat_q == nbeats_q - BEAT_W'(1)) begin
        state_d = S_DRAIN;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
      S_DRAIN: if (cap_last) begin
        state_d = S_DONE;
        ready_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lanes landing at or past len are dropped so the tail stays zero.
  always_comb begin
    vec_d = vec_q;
    if (accept) vec_d = '0;
    for (int e = 0; e < DEPTH; e++)
      if (cap && (int'(cap_idx) == e / LANES) && (e < int'(len_q)))
        vec_d[e] = bus.bram_dout[e % LANES];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      nbeats_q   <= '0;
      beat_q     <= '0;
      vld_pipe_q <= '0;
      idx_pipe_q <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      vec_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      nbeats_q   <= nbeats_d;
      beat_q     <= beat_d;
      vld_pipe_q <= vld_pipe_d;
      idx_pipe_q <= idx_pipe_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      vec_q      <= vec_d;
    end
  end

  assign bus.busy_o    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.done_o    = (state_q == S_DONE);
  assign bus.ready_o   = ready_q;
  assign bus.err_o     = err_q;
  assign bus.bram_en   = issue;
  assign bus.bram_addr = addr_q;
  assign vec_o         = vec_q;
endmodule
